// File: rtl/constants_pkg.sv
// Shared architectural constants for the front end.
package constants_pkg;

    localparam int unsigned ARCH_LEN = 32;
    localparam int unsigned INST_LEN = 32;
    localparam int unsigned IQ_DEPTH = 4;

    localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;

endpackage : constants_pkg

// File: rtl/instruction_pkg.sv
// Instruction payload types passed between fetch and decode.
package instruction_pkg;

    import constants_pkg::*;

    typedef struct packed {
        logic [ARCH_LEN-1:0] pc;
        logic [INST_LEN-1:0] inst;
    } iq_entry_t;

endpackage : instruction_pkg

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: register-array FIFO with
// separate occupancy count and fully registered head/status outputs.
module inst_queue
    import constants_pkg::*;
    import instruction_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_in,
    input  logic                      enq_valid_in,
    input  logic [ARCH_LEN-1:0]       enq_pc_in,
    input  logic [INST_LEN-1:0]       enq_inst_in,
    output logic                      enq_ready_out,
    output logic                      deq_valid_out,
    output logic [ARCH_LEN-1:0]       deq_pc_out,
    output logic [INST_LEN-1:0]       deq_inst_out,
    input  logic                      deq_ready_in,
    output logic [$clog2(DEPTH):0]    count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq_ready_q, enq_ready_d;
    logic             deq_valid_q, deq_valid_d;
    iq_entry_t        head_entry_q, head_entry_d;

    logic do_enq;
    logic do_deq;

    assign do_enq = enq_valid_in & enq_ready_q & ~flush_in;
    assign do_deq = deq_valid_q & deq_ready_in & ~flush_in;

    // Next pointer/count/storage state, then the head view derived from it
    // so the outputs can be registered without a fall-through path.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) begin
                mem_d[tail_q] = '{pc: enq_pc_in, inst: enq_inst_in};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (do_deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        enq_ready_d  = (count_d != CNT_W'(DEPTH));
        deq_valid_d  = (count_d != '0);
        head_entry_d = '{pc: '0, inst: NOP_INST};
        if (deq_valid_d) begin
            head_entry_d = mem_d[head_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            enq_ready_q  <= 1'b1;
            deq_valid_q  <= 1'b0;
            head_entry_q <= '{pc: '0, inst: NOP_INST};
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            enq_ready_q  <= enq_ready_d;
            deq_valid_q  <= deq_valid_d;
            head_entry_q <= head_entry_d;
        end
    end

    // Payload storage is never exposed while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign enq_ready_out = enq_ready_q;
    assign deq_valid_out = deq_valid_q;
    assign deq_pc_out    = head_entry_q.pc;
    assign deq_inst_out  = head_entry_q.inst;
    assign count_out     = count_q;

endmodule : inst_queue
